shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Multi-cycle shift controller that performs shift-by-N operations by iterating a single-bit shift step, one step per clock. It accepts a start request with operand, opcode and amount, runs a down-counter FSM and pulses done when the result is valid. It sits beside the ALU in the processor datapath and serves the SLL/SRL/SRA/ROL instructions when the control unit stalls the pipeline on busy.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 5, shift-amount width; must satisfy 2^CNT_W >= WIDTH

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk only when busy=0
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
amount  input  CNT_W  shift distance 0..WIDTH-1
data_in  input  WIDTH  operand
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse: result valid
result  output  WIDTH  shift register contents; final value valid from done until next accepted start
zero  output  1  result == 0; meaningful only with done or in IDLE

Behaviour:
- One clock; reset asynchronous, active-low (rst_n); all state is cleared immediately on rst_n=0, with no dependence on clk.
- Reset values: state=IDLE, busy=0, done=0, result=0, zero=1, internal cnt=0, latched op=00.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
- Accept: start=1 at a rising edge while the state is IDLE or DONE (back-to-back is allowed).
  - Load shift reg <= data_in, cnt <= amount, and latch op.
  - If amount==0, go to DONE; otherwise go to SHIFT.
- SHIFT: on each edge, apply one 1-bit step to the shift reg and decrement cnt.
  - SLL: {reg[W-2:0],0}.
  - SRL: {0,reg[W-1:1]}.
  - SRA: {reg[W-1],reg[W-1:1]}.
  - ROL: {reg[W-2:0],reg[W-1]}.
  - When cnt==1 at the edge, perform the final step and go to DONE.
- DONE lasts exactly one cycle. Without an accepted start it then returns to IDLE, and result is held.
- Latency: with the start sampled at edge 0, done is high in the cycle after edge N for N>=1, and in the cycle after edge 0 for N=0. Exactly N step edges occur.
- start while busy=1 is ignored. data_in, op and amount are don't-care after acceptance.
- result is visible during SHIFT as the intermediate value; consumers must qualify it with done.
- zero is combinational from the shift register.
- rst_n asserted mid-SHIFT aborts the operation: no done pulse and result=0. Operation resumes from IDLE on the first edge after rst_n deasserts.
- Amounts >= WIDTH are illegal when WIDTH < 2^CNT_W; the behaviour is the iterative result (no saturation) and is not verified.

Test Plan:
1. Reset, then start op=00, data_in=0x00000001, amount=4 -> busy high for edges 1..4; done pulse after edge 4; result=0x00000010, zero=0.
2. op=10, data_in=0x80000000, amount=31 -> busy for 31 cycles; done after edge 31; result=0xFFFFFFFF. Repeat with op=01 -> result=0x00000001.
3. amount=0, op=00, data_in=0xDEADBEEF -> done in the cycle after the start edge; busy never high; result=0xDEADBEEF.
4. op=11, data_in=0x80000001, amount=1 -> result=0x00000003. Then, back-to-back with start in the DONE cycle: op=01, data_in=0x00000000, amount=3 -> a second done 3 cycles later; result=0, zero=1.
5. Start SLL 0x1 by 8; at edge 3, assert start with data_in=0xFFFFFFFF -> ignored; final result=0x00000100 after edge 8.
6. Start SLL 0x1 by 10; assert rst_n=0 asynchronously mid-cycle after edge 5 -> busy=0 and result=0 immediately; no done pulse. Release reset, start SRL 0x100 by 8 -> result=0x00000001.

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Purpose  : Multi-cycle shifter for SLL/SRL/SRA/ROL. A start request loads
//             the operand and shift distance, then one 1-bit shift step is
//             applied per clock until the distance is used up. The result is
//             reported with a one-cycle done pulse.
//  Ports    : clk      - system clock, rising edge active
//             rst_n    - asynchronous active-low reset
//             start    - request, accepted only when not busy
//             op       - 00 SLL, 01 SRL, 10 SRA, 11 ROL
//             amount   - shift distance 0..WIDTH-1
//             data_in  - operand
//             busy     - high while shifting
//             done     - one-cycle pulse, result valid
//             result   - shift register contents (intermediate while busy)
//             zero     - result == 0
//  Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_OP_SLL = 2'b00;
    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;
    localparam logic [1:0] c_OP_ROL = 2'b11;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         w_op_nxt;
    logic [WIDTH-1:0]   w_step;
    logic               w_accept;

    // Single 1-bit step of the latched operation applied to the shift register.
    always_comb begin
        w_step = r_sreg;
        case (r_op)
            c_OP_SLL: w_step = {r_sreg[WIDTH-2:0], 1'b0};
            c_OP_SRL: w_step = {1'b0, r_sreg[WIDTH-1:1]};
            c_OP_SRA: w_step = {r_sreg[WIDTH-1], r_sreg[WIDTH-1:1]};
            c_OP_ROL: w_step = {r_sreg[WIDTH-2:0], r_sreg[WIDTH-1]};
            default:  w_step = r_sreg;
        endcase
    end

    // A new request may be taken in IDLE and also in DONE, which lets the
    // control unit issue back-to-back shifts without an idle bubble.
    assign w_accept = start && (r_state != S_SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_sreg_nxt  = data_in;
                    w_cnt_nxt   = amount;
                    w_op_nxt    = op;
                    // A zero-distance shift skips SHIFT and reports at once.
                    w_state_nxt = (amount == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_sreg_nxt = w_step;
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_op    <= c_OP_SLL;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign busy   = (r_state == S_SHIFT);
    assign done   = (r_state == S_DONE);
    assign result = r_sreg;
    assign zero   = (r_sreg == '0);

endmodule
`default_nettype wire
